// File: rtl/fp16_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : fp16_accumulator
// Description : Sequential FP16 adder. Accepts one half-precision term at a
//               time, folds it into a running sum through an
//               ALIGN/ADD/NORM/ROUND pipeline walked by a small FSM, and
//               presents the rounded sum after N_TERMS terms.
//               Rounding is round-to-nearest-even. Subnormal inputs and
//               results flush to +0. Any exponent-31 input latches a sticky
//               quiet NaN (0x7E00) for the rest of the result.
//               Build option: define FP16_ACC_SAT_EN to saturate overflow to
//               +/-max-finite (0x7BFF). Without it, overflow gives +/-infinity.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_accumulator #(
    parameter int N_TERMS = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    localparam logic [15:0] c_QNAN = 16'h7E00;
`ifdef FP16_ACC_SAT_EN
    localparam logic [14:0] c_OVF  = 15'h7BFF;
`else
    localparam logic [14:0] c_OVF  = 15'h7C00;
`endif

    typedef enum logic [2:0] {
        ST_ACCEPT = 3'd0,
        ST_ALIGN  = 3'd1,
        ST_ADD    = 3'd2,
        ST_NORM   = 3'd3,
        ST_ROUND  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_acc;
    logic [7:0]  r_count;
    logic        r_nan;
    logic [15:0] r_term;

    // Pipeline state carried between the arithmetic steps
    logic [13:0] r_sig_a;   // larger significand {hidden, mant, G, R, S}
    logic [13:0] r_sig_b;   // aligned smaller significand
    logic [7:0]  r_exp;     // working exponent; bit 7 acts as a sign
    logic        r_sign;
    logic        r_sub;
    logic        r_skip;    // term is ignored because of NaN
    logic        r_hold;    // accumulator is infinity and stays put
    logic [14:0] r_sum;
    logic [13:0] r_norm;
    logic        r_zero;

    // ------------------------------------------------------------------
    // ALIGN: order operands by magnitude and align the smaller one
    // ------------------------------------------------------------------
    logic [14:0] w_acc_mag;
    logic [14:0] w_trm_mag;
    logic        w_swap;
    logic [14:0] w_big_mag;
    logic [14:0] w_sml_mag;
    logic        w_big_sign;
    logic        w_sml_sign;
    logic [13:0] w_big_sig;
    logic [13:0] w_sml_sig;
    logic [4:0]  w_shift;
    logic [13:0] w_shifted;
    logic [13:0] w_lost;
    logic [13:0] w_sml_aln;

    // Exponent-0 values are flushed to a zero magnitude before comparison
    assign w_acc_mag  = (r_acc[14:10]  == 5'd0) ? 15'd0 : r_acc[14:0];
    assign w_trm_mag  = (r_term[14:10] == 5'd0) ? 15'd0 : r_term[14:0];
    assign w_swap     = (w_trm_mag > w_acc_mag);
    assign w_big_mag  = w_swap ? w_trm_mag : w_acc_mag;
    assign w_sml_mag  = w_swap ? w_acc_mag : w_trm_mag;
    assign w_big_sign = w_swap ? r_term[15] : r_acc[15];
    assign w_sml_sign = w_swap ? r_acc[15]  : r_term[15];
    assign w_big_sig  = (w_big_mag == 15'd0) ? 14'd0 : {1'b1, w_big_mag[9:0], 3'b000};
    assign w_sml_sig  = (w_sml_mag == 15'd0) ? 14'd0 : {1'b1, w_sml_mag[9:0], 3'b000};
    assign w_shift    = w_big_mag[14:10] - w_sml_mag[14:10];

    // Bits shifted past the LSB collapse into sticky; a shift of 14 or more
    // moves everything out, leaving only the sticky bit.
    assign w_shifted  = w_sml_sig >> w_shift;
    assign w_lost     = w_sml_sig & ~(14'h3FFF << w_shift);
    assign w_sml_aln  = {w_shifted[13:1], w_shifted[0] | (|w_lost)};

    // ------------------------------------------------------------------
    // NORM: leading-zero count and renormalisation
    // ------------------------------------------------------------------
    logic [3:0]  w_lzc;
    logic [13:0] w_norm;
    logic [7:0]  w_nexp;
    logic        w_nzero;

    // Leading-zero count of the 14-bit sum (14 when the sum is zero)
    always_comb begin
        w_lzc = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (r_sum[i]) begin
                w_lzc = 4'(13 - i);
            end
        end
    end

    // Normalise: right by one on carry-out, otherwise left by the lzc
    always_comb begin
        w_norm  = 14'd0;
        w_nexp  = r_exp;
        w_nzero = 1'b0;
        if (r_sum[14]) begin
            w_norm = {r_sum[14:2], r_sum[1] | r_sum[0]};
            w_nexp = r_exp + 8'd1;
        end else if (r_sum[13:0] == 14'd0) begin
            w_nzero = 1'b1;
        end else begin
            w_norm = r_sum[13:0] << w_lzc;
            w_nexp = r_exp - {4'd0, w_lzc};
        end
        // A result exponent of zero or below is subnormal and flushes
        if (w_nexp[7] || (w_nexp == 8'd0)) begin
            w_nzero = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // ROUND: round-to-nearest-even and final packing
    // ------------------------------------------------------------------
    logic        w_rnd_up;
    logic [11:0] w_rsig;
    logic [7:0]  w_rexp;
    logic [9:0]  w_rman;
    logic [15:0] w_result;
    logic [7:0]  w_count_inc;

    assign w_rnd_up    = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
    assign w_rsig      = {1'b0, r_norm[13:3]} + {11'd0, w_rnd_up};
    assign w_rexp      = r_exp + {7'd0, w_rsig[11]};
    assign w_rman      = w_rsig[11] ? w_rsig[10:1] : w_rsig[9:0];
    assign w_count_inc = r_count + 8'd1;

    // Pack the rounded sum; exact zeros are always +0
    always_comb begin
        w_result = {r_sign, w_rexp[4:0], w_rman};
        if (r_zero) begin
            w_result = 16'h0000;
        end else if (w_rexp > 8'd30) begin
            w_result = {r_sign, c_OVF};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_data     = 16'h0000;
        busy         = 1'b1;
        case (r_state)
            ST_ACCEPT: begin
                busy     = 1'b0;
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_state_next = ST_ALIGN;
                end
            end
            ST_ALIGN: w_state_next = ST_ADD;
            ST_ADD:   w_state_next = ST_NORM;
            ST_NORM:  w_state_next = ST_ROUND;
            ST_ROUND: begin
                w_state_next = (w_count_inc == 8'(N_TERMS)) ? ST_DONE : ST_ACCEPT;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_data  = r_acc;
                if (out_ready) begin
                    w_state_next = ST_ACCEPT;
                end
            end
            default: w_state_next = ST_ACCEPT;
        endcase
    end

    // Datapath: each state loads the registers of its own step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= 16'h0000;
            r_count <= 8'd0;
            r_nan   <= 1'b0;
            r_term  <= 16'h0000;
            r_sig_a <= 14'd0;
            r_sig_b <= 14'd0;
            r_exp   <= 8'd0;
            r_sign  <= 1'b0;
            r_sub   <= 1'b0;
            r_skip  <= 1'b0;
            r_hold  <= 1'b0;
            r_sum   <= 15'd0;
            r_norm  <= 14'd0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (in_valid) begin
                        r_term <= in_data;
                    end
                end
                ST_ALIGN: begin
                    r_sig_a <= w_big_sig;
                    r_sig_b <= w_sml_aln;
                    r_exp   <= {3'd0, w_big_mag[14:10]};
                    r_sign  <= w_big_sign;
                    r_sub   <= w_big_sign ^ w_sml_sign;
                    r_skip  <= r_nan | (r_term[14:10] == 5'h1F);
                    r_hold  <= (r_acc[14:10] == 5'h1F);
                end
                ST_ADD: begin
                    // Larger magnitude is first, so the difference is never negative
                    r_sum <= r_sub ? ({1'b0, r_sig_a} - {1'b0, r_sig_b})
                                   : ({1'b0, r_sig_a} + {1'b0, r_sig_b});
                end
                ST_NORM: begin
                    r_norm <= w_norm;
                    r_exp  <= w_nexp;
                    r_zero <= w_nzero;
                end
                ST_ROUND: begin
                    r_count <= w_count_inc;
                    if (r_skip) begin
                        r_nan <= 1'b1;
                        r_acc <= c_QNAN;
                    end else if (!r_hold) begin
                        r_acc <= w_result;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_acc   <= 16'h0000;
                        r_count <= 8'd0;
                        r_nan   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp16_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp16_accumulator
// Description : Self-checking bench for fp16_accumulator. Three instances
//               (N_TERMS = 9, 2, 3) are exercised with directed and random
//               terms; expected sums come from a real-number model that
//               rounds each partial sum to FP16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp16_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] in_data   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] out_data  [3];
    logic        busy      [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp16_accumulator #(.N_TERMS(9)) u_dut9 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    fp16_accumulator #(.N_TERMS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    fp16_accumulator #(.N_TERMS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2])
    );

    // ---------------- reference model ----------------

    function automatic real f2r(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = real'(1024 + int'(h[9:0]));
        e = int'(h[14:10]) - 25;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] ovf_val(input logic s);
`ifdef FP16_ACC_SAT_EN
        return {s, 15'h7BFF};
`else
        return {s, 15'h7C00};
`endif
    endfunction

    // Round an exact real to FP16 (nearest-even, flush below 2^-14)
    function automatic logic [15:0] r2f(input real x);
        logic s;
        real  a, m, fl;
        int   e;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        a = s ? -x : x;
        if (a < 6.103515625e-05) return 16'h0000;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m  = a * 1024.0;
        fl = $floor(m);
        if ((m - fl > 0.5) || ((m - fl == 0.5) && (int'(fl) % 2 == 1))) fl = fl + 1.0;
        if (fl >= 2048.0) begin fl = 1024.0; e++; end
        if (e > 15) return ovf_val(s);
        return {s, 5'(e + 15), 10'(int'(fl) - 1024)};
    endfunction

    function automatic logic [15:0] model_sum(input logic [15:0] t[$]);
        logic [15:0] acc;
        bit          nan;
        acc = 16'h0000;
        nan = 1'b0;
        foreach (t[i]) begin
            if (t[i][14:10] == 5'h1F) nan = 1'b1;
            else if (!nan && acc[14:10] != 5'h1F) acc = r2f(f2r(acc) + f2r(t[i]));
        end
        return nan ? 16'h7E00 : acc;
    endfunction

    function automatic logic [15:0] rand_term(input int lo, input int hi);
        logic [15:0] t;
        t[15]    = 1'($urandom_range(0, 1));
        t[14:10] = 5'($urandom_range(lo, hi));
        t[9:0]   = 10'($urandom);
        if ($urandom_range(0, 9) == 0) t[14:10] = 5'd0;
        return t;
    endfunction

    // ---------------- drivers ----------------

    task automatic send_term(input int s, input logic [15:0] d, output int acc_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready[s] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (in_ready[s] !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_timeout dut%0d actual=%b required=1", s, in_ready[s]);
            acc_cyc = -1;
        end else begin
            in_valid[s] = 1'b1;
            in_data[s]  = d;
            @(posedge clk); #1;
            in_valid[s] = 1'b0;
            acc_cyc     = cyc;
        end
    endtask

    task automatic get_result(input int s, output logic [15:0] d, output int vcyc);
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid[s] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (out_valid[s] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout dut%0d actual=%b required=1", s, out_valid[s]);
            d    = 16'hxxxx;
            vcyc = -1;
        end else begin
            d    = out_data[s];
            vcyc = cyc;
            out_ready[s] = 1'b1;
            @(posedge clk); #1;
            out_ready[s] = 1'b0;
        end
    endtask

    task automatic run_group(input int s, input logic [15:0] t[$],
                             output logic [15:0] res, output int lat);
        int a, a0, vc;
        a0 = -1;
        foreach (t[i]) begin
            send_term(s, t[i], a);
            if (i == 0) a0 = a;
        end
        get_result(s, res, vc);
        lat = (a0 < 0 || vc < 0) ? -1 : vc - a0;
    endtask

    // ---------------- tests ----------------

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (in_ready[s] !== 1'b0 || out_valid[s] !== 1'b0 ||
                out_data[s] !== 16'h0000 || busy[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d actual=%b%b%h%b required=0000000",
                         s, in_ready[s], out_valid[s], out_data[s], busy[s]);
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (in_ready[s] !== 1'b1 || busy[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_release dut%0d in_ready=%b busy=%b required=1/0",
                         s, in_ready[s], busy[s]);
            end
        end
    endtask

    task automatic test_sum_ones9();
        logic [15:0] t[$];
        logic [15:0] r;
        int lat;
        for (int i = 0; i < 9; i++) t.push_back(16'h3C00);
        run_group(0, t, r, lat);
        checks++;
        if (r !== 16'h4880) begin
            errors++;
            $display("FAIL nine_ones actual=%h required=4880", r);
        end
        checks++;
        if (lat < 44 || lat > 46) begin
            errors++;
            $display("FAIL nine_ones_latency actual=%0d required=44..46", lat);
        end
    endtask

    task automatic test_cancel_and_tie();
        logic [15:0] r;
        int lat;
        run_group(1, '{16'h3C00, 16'hBC00}, r, lat);
        checks++;
        if (r !== 16'h0000) begin
            errors++;
            $display("FAIL cancel actual=%h required=0000", r);
        end
        run_group(1, '{16'h6800, 16'h3C00}, r, lat);
        checks++;
        if (r !== 16'h6800) begin
            errors++;
            $display("FAIL tie_even actual=%h required=6800", r);
        end
        run_group(1, '{16'h8000, 16'h8000}, r, lat);
        checks++;
        if (r !== 16'h0000) begin
            errors++;
            $display("FAIL neg_zero actual=%h required=0000", r);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] r;
        logic [15:0] exp_v;
        int lat;
`ifdef FP16_ACC_SAT_EN
        exp_v = 16'h7BFF;
`else
        exp_v = 16'h7C00;
`endif
        run_group(1, '{16'h7BFF, 16'h7BFF}, r, lat);
        checks++;
        if (r !== exp_v) begin
            errors++;
            $display("FAIL overflow_pos actual=%h required=%h", r, exp_v);
        end
        run_group(1, '{16'hFBFF, 16'hFBFF}, r, lat);
        checks++;
        if (r !== {1'b1, exp_v[14:0]}) begin
            errors++;
            $display("FAIL overflow_neg actual=%h required=%h", r, {1'b1, exp_v[14:0]});
        end
    endtask

    task automatic test_nan_sticky();
        logic [15:0] r;
        int lat;
        run_group(2, '{16'h3C00, 16'h7C00, 16'h3C00}, r, lat);
        checks++;
        if (r !== 16'h7E00) begin
            errors++;
            $display("FAIL nan_sticky actual=%h required=7E00", r);
        end
        run_group(2, '{16'h4000, 16'h4000, 16'h4000}, r, lat);
        checks++;
        if (r !== 16'h4600) begin
            errors++;
            $display("FAIL nan_cleared actual=%h required=4600", r);
        end
    endtask

    task automatic test_hold_done();
        logic [15:0] first;
        int a, n;
        send_term(1, 16'h4000, a);
        send_term(1, 16'h4000, a);
        n = 0;
        @(negedge clk);
        while (out_valid[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        first = out_data[1];
        checks++;
        if (out_valid[1] !== 1'b1 || first !== 16'h4400) begin
            errors++;
            $display("FAIL hold_first actual=%b/%h required=1/4400", out_valid[1], first);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== first || in_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle%0d actual=%b/%h/%b required=1/%h/0",
                         k, out_valid[1], out_data[1], in_ready[1], first);
            end
        end
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        checks++;
        if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL hold_release actual=%b/%b/%b required=1/0/0",
                     in_ready[1], out_valid[1], busy[1]);
        end
    endtask

    task automatic test_reset_mid_add();
        logic [15:0] t[$];
        logic [15:0] r;
        int a, lat;
        for (int i = 0; i < 4; i++) send_term(0, 16'h3C00, a);
        @(posedge clk); #1;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_add_busy actual=%b required=1", busy[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 ||
            out_data[0] !== 16'h0000 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_add_reset actual=%b%b%h%b required=0000000",
                     in_ready[0], out_valid[0], out_data[0], busy[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL abandoned_term actual=%b/%b required=0/0", out_valid[0], busy[0]);
        end
        for (int i = 0; i < 9; i++) t.push_back(16'h3C00);
        run_group(0, t, r, lat);
        checks++;
        if (r !== 16'h4880) begin
            errors++;
            $display("FAIL after_reset_sum actual=%h required=4880", r);
        end
    endtask

    task automatic test_random(input int s, input int nterms, input int groups,
                               input int lo, input int hi);
        logic [15:0] t[$];
        logic [15:0] r, e;
        logic [15:0] x;
        int lat;
        for (int g = 0; g < groups; g++) begin
            t.delete();
            for (int i = 0; i < nterms; i++) begin
                if (i > 0 && $urandom_range(0, 2) == 0) begin
                    // near-cancellation against the previous term
                    x = t[i-1];
                    t.push_back({~x[15], x[14:10], x[9:0] ^ 10'($urandom_range(0, 7))});
                end else if ($urandom_range(0, 39) == 0) begin
                    t.push_back({1'($urandom_range(0, 1)), 5'h1F, 10'($urandom)});
                end else begin
                    t.push_back(rand_term(lo, hi));
                end
            end
            e = model_sum(t);
            run_group(s, t, r, lat);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL random dut%0d group%0d actual=%h required=%h", s, g, r, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in_valid[s]  = 1'b0;
            in_data[s]   = 16'h0000;
            out_ready[s] = 1'b0;
        end
        test_reset();
        test_sum_ones9();
        test_cancel_and_tie();
        test_overflow();
        test_nan_sticky();
        test_hold_done();
        test_reset_mid_add();
        test_random(0, 9, 6, 12, 18);
        test_random(1, 2, 30, 1, 30);
        test_random(2, 3, 12, 5, 25);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp16_accumulator.md
FP16_ACCUMULATOR -- requirements
Module: fp16_accumulator

Interface
REQ-001 SHALL have parameter: N_TERMS, 9, number of FP16 terms summed per result (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  in_data holds a term.
REQ-005 SHALL have port: in_ready  output  1  block accepts a term this cycle.
REQ-006 SHALL have port: in_data  input  16  FP16 term (sign, 5-bit exponent, 10-bit mantissa) from the int-to-FP16 converter.
REQ-007 SHALL have port: out_valid  output  1  out_data holds a finished sum.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts the sum.
REQ-009 SHALL have port: out_data  output  16  FP16 sum of N_TERMS terms.
REQ-010 SHALL have port: busy  output  1  high in any state other than ACCEPT.

Function
REQ-011 SHALL implement FSM states ACCEPT, ALIGN, ADD, NORM, ROUND, DONE.
REQ-012 SHALL, in ACCEPT, drive in_ready=1; on in_valid&&in_ready, capture in_data, go to ALIGN.
REQ-013 SHALL step ALIGN->ADD->NORM->ROUND, one cycle each; in_ready=0 throughout.
REQ-014 SHALL, at ROUND exit, increment term count; if count==N_TERMS go DONE, else ACCEPT (5 cycles per term minimum).
REQ-015 SHALL, in DONE, hold out_valid=1 and out_data stable until out_ready=1; on that edge clear accumulator to +0, count to 0, sticky-NaN flag to 0, and go ACCEPT.
REQ-016 SHALL never assert in_ready and out_valid in the same cycle.
REQ-017 ALIGN SHALL swap operands so the larger magnitude is first and right-shift the smaller significand (hidden bit included) by the exponent difference, keeping guard, round and sticky bits; shifts >=14 leave only sticky.
REQ-018 ADD SHALL add or subtract significands per sign equality; result sign is the larger-magnitude operand's sign.
REQ-019 NORM SHALL left-shift by leading-zero count or right-shift by 1 on carry-out, adjusting exponent accordingly, in one cycle.
REQ-020 ROUND SHALL apply round-to-nearest-even on guard/round/sticky; mantissa carry-out increments exponent.
REQ-021 SHALL flush subnormal inputs (exponent 0) and subnormal results to +0.
REQ-022 SHALL produce +0 for any exact-zero result, including -0 + -0.
REQ-023 SHALL treat any input with exponent 31 as invalid: set sticky-NaN flag; while set, accumulator is 0x7E00 and further terms are consumed but ignored.
REQ-024 SHALL, on exponent overflow (>30 after rounding), produce overflow value per REQ-029/030 with the result sign.

Reset
REQ-025 SHALL, while rst_n=0, force state ACCEPT, accumulator +0, count 0, sticky-NaN flag 0, immediately without clock.
REQ-026 SHALL reset outputs to in_ready=1 (after rst_n release; 0 during reset), out_valid=0, out_data=16'h0000, busy=0.
REQ-027 SHALL abandon any in-flight term or held result on reset; nothing is emitted afterwards for it.

Configuration
REQ-028 SHALL compile overflow saturation in/out by macro FP16_ACC_SAT_EN.
REQ-029 SHALL, with FP16_ACC_SAT_EN defined, saturate overflow to sign|0x7BFF (max finite).
REQ-030 SHALL, without FP16_ACC_SAT_EN, produce sign|0x7C00 (infinity) on overflow.

Verification
REQ-031 N_TERMS=9, nine 0x3C00 (1.0) -> out_data=0x4880 (9.0), out_valid first high 45 cycles after first accepted term's edge +/-1.
REQ-032 N_TERMS=2, 0x3C00 then 0xBC00 -> out_data=0x0000; then 0x6800 (2048) + 0x3C00 -> 0x6800 (tie to even).
REQ-033 N_TERMS=2, 0x7BFF + 0x7BFF -> 0x7C00 without macro, 0x7BFF with FP16_ACC_SAT_EN.
REQ-034 N_TERMS=3, 0x3C00, 0x7C00, 0x3C00 -> 0x7E00; next result with three 0x4000 -> 0x4600 (flag cleared).
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> out_valid=1, out_data stable, in_ready=0 throughout; accepted on out_ready=1, in_ready=1 next cycle.
REQ-036 Assert rst_n=0 during ADD of term 4 -> outputs at reset values same cycle; after release, nine 0x3C00 -> 0x4880.
